// File: rtl/systolic_array_arbiter_pkg.sv
// Shared hyper-parameters and FSM encodings for systolic_array_arbiter.
// Default-width fallbacks apply only when the surrounding build has not set them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SYSTOLIC_UNIT_NUM
`define SYSTOLIC_UNIT_NUM 4
`endif

package systolic_array_arbiter_pkg;
  localparam int DATA_W   = `DATA_WIDTH;
  localparam int UNIT_NUM = `SYSTOLIC_UNIT_NUM;
  localparam int WDOG_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/systolic_array_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr,
// wrapping at REQ_NUM-1 -> 0, returned one-hot (all zero when req is empty).
module systolic_array_arbiter_rr_pick #(
  parameter int REQ_NUM = 3,
  parameter int PTR_W   = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [REQ_NUM-1:0] pick
);
  function automatic int wrap_idx(input int x);
    return (x >= REQ_NUM) ? x - REQ_NUM : x;
  endfunction

  // Walk offsets farthest-first so the nearest hit to ptr overwrites the rest.
  always_comb begin
    pick = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (req[i] && (i == wrap_idx(int'(ptr) + k))) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/systolic_array_arbiter.sv
// Round-robin owner arbiter muxing Q/K/V controllers onto one systolic array.
// Optional watchdog force-release is built when SYSARB_WATCHDOG_EN is defined.
module systolic_array_arbiter
  import systolic_array_arbiter_pkg::*;
#(
  parameter int REQ_NUM     = 3,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                                  s_clk,
  input  logic                                  s_rst_n,
  input  logic [REQ_NUM-1:0]                    i_req,
  input  logic [REQ_NUM-1:0]                    i_release,
  output logic [REQ_NUM-1:0]                    o_grant,
  input  logic [REQ_NUM-1:0]                    i_init_prep,
  output logic                                  o_Init_PrepareData,
  input  logic [REQ_NUM-1:0]                    i_mtrxA_valid,
  input  logic [REQ_NUM-1:0]                    i_mtrxA_done,
  input  logic [REQ_NUM*`DATA_WIDTH-1:0]        i_mtrxA_data,
  output logic [REQ_NUM-1:0]                    o_mtrxA_ready,
  output logic                                  MtrxA_slice_valid,
  output logic                                  MtrxA_slice_done,
  output logic [`DATA_WIDTH-1:0]                MtrxA_slice_data,
  input  logic                                  MtrxA_slice_ready,
  input  logic [REQ_NUM-1:0]                    i_mtrxB_valid,
  input  logic [REQ_NUM-1:0]                    i_mtrxB_done,
  input  logic [REQ_NUM*`DATA_WIDTH-1:0]        i_mtrxB_data,
  output logic [REQ_NUM-1:0]                    o_mtrxB_ready,
  output logic                                  MtrxB_slice_valid,
  output logic                                  MtrxB_slice_done,
  output logic [`DATA_WIDTH-1:0]                MtrxB_slice_data,
  input  logic                                  MtrxB_slice_ready,
  input  logic                                  i_Finish_Calc,
  output logic [REQ_NUM-1:0]                    o_finish_calc,
  input  logic [REQ_NUM*`SYSTOLIC_UNIT_NUM-1:0] i_psum_grant,
  input  logic [REQ_NUM-1:0]                    i_psum_valid,
  output logic [`SYSTOLIC_UNIT_NUM-1:0]         o_PsumFIFO_Grant,
  output logic                                  o_PsumFIFO_Valid,
  output logic                                  o_stray_err,
  output logic                                  o_wdog_err
);
  localparam int PTR_W = ptr_width(REQ_NUM);

  state_t             state_reg, state_next;
  logic [REQ_NUM-1:0] grant_reg, grant_next, pick;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next, owner_idx, owner_inc;
  logic               stray_reg, stray_next;
  logic               release_hit, wdog_fire, busy_exit;

  systolic_array_arbiter_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req  (i_req),
    .ptr  (rr_ptr_reg),
    .pick (pick)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_reg[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_inc   = (owner_idx == PTR_W'(REQ_NUM - 1)) ? '0 : owner_idx + PTR_W'(1);
  assign release_hit = (state_reg == S_BUSY) && (|(i_release & grant_reg));
  assign busy_exit   = release_hit || wdog_fire;

`ifdef SYSARB_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_err_reg;

  assign wdog_fire  = (state_reg == S_BUSY) && (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));
  assign o_wdog_err = wdog_err_reg;

  // Counter sits at zero outside S_BUSY, so every ownership starts from a clean count.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_cnt_reg <= ((state_reg == S_BUSY) && !busy_exit) ? wdog_cnt_reg + WDOG_W'(1) : '0;
      wdog_err_reg <= wdog_fire;
    end
  end
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_fire  = 1'b0;
  assign o_wdog_err = 1'b0;
`endif

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg  <= S_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      stray_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      stray_reg  <= stray_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (|i_req) state_next = S_ARB;
      S_ARB:   state_next = (|i_req) ? S_BUSY : S_IDLE;
      S_BUSY:  if (busy_exit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      S_ARB:  grant_next = pick;
      S_BUSY: begin
        if (busy_exit) begin
          grant_next  = '0;
          rr_ptr_next = owner_inc;
        end
      end
      default: grant_next = '0;
    endcase
    stray_next = stray_reg | (i_Finish_Calc & ~(|grant_reg));
  end

  assign o_grant     = grant_reg;
  assign o_stray_err = stray_reg;

  // Zero-latency forwarding; grant_reg is one-hot, so AND-OR muxing suffices.
  assign MtrxA_slice_valid  = |(i_mtrxA_valid & grant_reg);
  assign MtrxA_slice_done   = |(i_mtrxA_done & grant_reg);
  assign MtrxB_slice_valid  = |(i_mtrxB_valid & grant_reg);
  assign MtrxB_slice_done   = |(i_mtrxB_done & grant_reg);
  assign o_Init_PrepareData = |(i_init_prep & grant_reg);
  assign o_PsumFIFO_Valid   = |(i_psum_valid & grant_reg);
  assign o_mtrxA_ready      = grant_reg & {REQ_NUM{MtrxA_slice_ready}};
  assign o_mtrxB_ready      = grant_reg & {REQ_NUM{MtrxB_slice_ready}};
  assign o_finish_calc      = grant_reg & {REQ_NUM{i_Finish_Calc}};

  always_comb begin
    MtrxA_slice_data = '0;
    MtrxB_slice_data = '0;
    o_PsumFIFO_Grant = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_reg[i]) begin
        MtrxA_slice_data = MtrxA_slice_data | i_mtrxA_data[i*DATA_W +: DATA_W];
        MtrxB_slice_data = MtrxB_slice_data | i_mtrxB_data[i*DATA_W +: DATA_W];
        o_PsumFIFO_Grant = o_PsumFIFO_Grant | i_psum_grant[i*UNIT_NUM +: UNIT_NUM];
      end
    end
  end
endmodule
